// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-port cache refill arbiter.
//   port_id_t         : identifies a requesting cache port
//   PORT_ICACHE/DCACHE: port 0 (icache refill) and port 1 (dcache refill)
//   MAX_OUTSTANDING_*  : legal range for the outstanding-transaction depth
package cache_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT_ICACHE = 1'b0;
  localparam port_id_t PORT_DCACHE = 1'b1;

  localparam int unsigned MAX_OUTSTANDING_MIN = 1;
  localparam int unsigned MAX_OUTSTANDING_MAX = 8;

  function automatic port_id_t other_port(port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the two cache request ports, the shared memory port and the error flag.
//   slave  : arbiter view (cache requests and memory responses in; grants, responses,
//            memory request and err_o out)
//   master : environment view (caches and memory model), the mirror image
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    port0_req_i,    port1_req_i;
  logic                    port0_gnt_o,    port1_gnt_o;
  logic                    port0_rvalid_o, port1_rvalid_o;
  logic [ADDR_WIDTH-1:0]   port0_addr_i,   port1_addr_i;
  logic                    port0_we_i,     port1_we_i;
  logic [DATA_WIDTH/8-1:0] port0_be_i,     port1_be_i;
  logic [DATA_WIDTH-1:0]   port0_wdata_i,  port1_wdata_i;
  logic [DATA_WIDTH-1:0]   port0_rdata_o,  port1_rdata_o;
  logic                    port0_lock_i,   port1_lock_i;

  logic                    mem_req_o;
  logic                    mem_gnt_i;
  logic                    mem_rvalid_i;
  logic [ADDR_WIDTH-1:0]   mem_addr_o;
  logic                    mem_we_o;
  logic [DATA_WIDTH/8-1:0] mem_be_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;

  logic                    err_o;

  modport slave (
    input  port0_req_i, port0_addr_i, port0_we_i, port0_be_i, port0_wdata_i, port0_lock_i,
    input  port1_req_i, port1_addr_i, port1_we_i, port1_be_i, port1_wdata_i, port1_lock_i,
    output port0_gnt_o, port0_rvalid_o, port0_rdata_o,
    output port1_gnt_o, port1_rvalid_o, port1_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output err_o
  );

  modport master (
    output port0_req_i, port0_addr_i, port0_we_i, port0_be_i, port0_wdata_i, port0_lock_i,
    output port1_req_i, port1_addr_i, port1_we_i, port1_be_i, port1_wdata_i, port1_lock_i,
    input  port0_gnt_o, port0_rvalid_o, port0_rdata_o,
    input  port1_gnt_o, port1_rvalid_o, port1_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  err_o
  );

endinterface

// File: rtl/arb_id_fifo.sv
// In-order FIFO of port IDs for granted-but-unanswered memory transactions.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/push_id_i : enqueue the granted port ID
//   pop_i            : dequeue the head (response returned)
//   head_o           : port ID owed the next response
//   full_o/empty_o   : occupancy flags
// Push and pop may coincide in any state, including full; the caller never pushes
// into a full FIFO without popping, nor pops an empty one.
module arb_id_fifo
  import cache_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  port_id_t push_id_i,
  input  logic     pop_i,
  output port_id_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  port_id_t        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_id_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory port between icache (port 0) and
// dcache (port 1) refills. Requests pass through combinationally; an ID FIFO of depth
// MAX_OUTSTANDING steers in-order responses back to the issuing port.
//   clk, rst_n : clock, synchronous active-low reset (all outputs 0 while low)
//   bus        : cache_mem_arbiter_if.slave (cache ports, memory port, err_o)
// Build option CACHE_ARB_LOCK_EN: portN_lock_i holds arbitration on port N for a burst.
// Without it lock inputs are ignored and arbitration is pure round-robin.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic                clk,
  input logic                rst_n,
  cache_mem_arbiter_if.slave bus
);

  localparam int unsigned FifoDepth = (MAX_OUTSTANDING > MAX_OUTSTANDING_MAX) ?
                                      MAX_OUTSTANDING_MAX : MAX_OUTSTANDING;

  logic [1:0]              req;
  port_id_t                sel, head;
  port_id_t                rr_q, rr_d;
  logic                    pend_v_q, pend_v_d;
  port_id_t                pend_port_q, pend_port_d;
  logic                    err_q, err_d;
  logic                    full, empty, pop, fwd, hs;
  logic                    lock_act;
  port_id_t                lock_sel;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_we;
  logic [DATA_WIDTH/8-1:0] sel_be;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  assign req = {bus.port1_req_i, bus.port0_req_i};

`ifdef CACHE_ARB_LOCK_EN
  logic       lock_v_q, lock_v_d;
  port_id_t   lock_port_q, lock_port_d;
  logic [1:0] lock_in;

  assign lock_in  = {bus.port1_lock_i, bus.port0_lock_i};
  // Lock only binds while its owner keeps requesting; dropping req releases it.
  assign lock_act = lock_v_q & req[lock_port_q];
  assign lock_sel = lock_port_q;

  always_comb begin
    lock_v_d    = lock_v_q;
    lock_port_d = lock_port_q;
    if (lock_v_q && !req[lock_port_q]) begin
      lock_v_d = 1'b0;
    end
    if (hs) begin
      if (lock_in[sel]) begin
        lock_v_d    = 1'b1;
        lock_port_d = sel;
      end else if (lock_v_q && sel == lock_port_q) begin
        lock_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_v_q    <= 1'b0;
      lock_port_q <= PORT_ICACHE;
    end else begin
      lock_v_q    <= lock_v_d;
      lock_port_q <= lock_port_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = bus.port0_lock_i ^ bus.port1_lock_i;
  assign lock_act    = 1'b0;
  assign lock_sel    = PORT_ICACHE;
`endif

  // Priority: active lock, then a request already shown to memory but not granted
  // (must not be swapped out), then lone requester, then round-robin.
  always_comb begin
    sel = PORT_ICACHE;
    if (lock_act) begin
      sel = lock_sel;
    end else if (pend_v_q && req[pend_port_q]) begin
      sel = pend_port_q;
    end else if (&req) begin
      sel = rr_q;
    end else if (req[PORT_DCACHE]) begin
      sel = PORT_DCACHE;
    end
  end

  always_comb begin
    sel_addr  = bus.port0_addr_i;
    sel_we    = bus.port0_we_i;
    sel_be    = bus.port0_be_i;
    sel_wdata = bus.port0_wdata_i;
    if (sel == PORT_DCACHE) begin
      sel_addr  = bus.port1_addr_i;
      sel_we    = bus.port1_we_i;
      sel_be    = bus.port1_be_i;
      sel_wdata = bus.port1_wdata_i;
    end
  end

  // A response popping this cycle frees a slot, so a full FIFO still forwards.
  assign pop = rst_n & bus.mem_rvalid_i & ~empty;
  assign fwd = rst_n & (|req) & (~full | pop);
  assign hs  = fwd & bus.mem_gnt_i;

  always_comb begin
    rr_d        = (hs && !lock_act) ? other_port(sel) : rr_q;
    pend_v_d    = pend_v_q;
    pend_port_d = pend_port_q;
    if (fwd) begin
      pend_v_d    = ~bus.mem_gnt_i;
      pend_port_d = sel;
    end else if (pend_v_q && !req[pend_port_q]) begin
      pend_v_d = 1'b0;
    end
    err_d = err_q | (bus.mem_rvalid_i & empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q        <= PORT_ICACHE;
      pend_v_q    <= 1'b0;
      pend_port_q <= PORT_ICACHE;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      pend_v_q    <= pend_v_d;
      pend_port_q <= pend_port_d;
      err_q       <= err_d;
    end
  end

  arb_id_fifo #(
    .Depth (FifoDepth)
  ) u_id_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .push_i    (hs),
    .push_id_i (sel),
    .pop_i     (pop),
    .head_o    (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign bus.mem_req_o      = fwd;
  assign bus.mem_addr_o     = rst_n ? sel_addr : '0;
  assign bus.mem_we_o       = rst_n & sel_we;
  assign bus.mem_be_o       = rst_n ? sel_be : '0;
  assign bus.mem_wdata_o    = rst_n ? sel_wdata : '0;

  assign bus.port0_gnt_o    = hs & (sel == PORT_ICACHE);
  assign bus.port1_gnt_o    = hs & (sel == PORT_DCACHE);
  assign bus.port0_rvalid_o = pop & (head == PORT_ICACHE);
  assign bus.port1_rvalid_o = pop & (head == PORT_DCACHE);
  assign bus.port0_rdata_o  = (pop && head == PORT_ICACHE) ? bus.mem_rdata_i : '0;
  assign bus.port1_rdata_o  = (pop && head == PORT_DCACHE) ? bus.mem_rdata_i : '0;
  assign bus.err_o          = rst_n & err_q;

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width on all ports.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2: granted-but-unanswered transactions allowed (1..8).
REQ-004 SHALL have one clock; reset is synchronous and active-low. Ports are clk and rst_n.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- portN_req_i  in  1  request (N = 0, 1; 0 = icache refill, 1 = dcache refill).
- portN_gnt_o  out  1  grant.
- portN_rvalid_o  out  1  response valid.
- portN_addr_i  in  ADDR_WIDTH  address.
- portN_we_i  in  1  write enable.
- portN_be_i  in  DATA_WIDTH/8  byte enables.
- portN_wdata_i  in  DATA_WIDTH  write data.
- portN_rdata_o  out  DATA_WIDTH  read data.
- portN_lock_i  in  1  hold arbitration (burst line refill).
- mem_req_o, mem_gnt_i, mem_rvalid_i, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, mem_rdata_i: shared memory port, same widths and meanings.
- err_o  out  1  sticky flag: unexpected mem_rvalid_i.

Function
REQ-006 SHALL select one port per cycle; mem_req_o, addr, we, be and wdata are driven combinationally from the selected port.
REQ-007 SHALL block forwarding when the ID FIFO holds MAX_OUTSTANDING entries: mem_req_o = 0 and no grants.
REQ-008 SHALL drive portN_gnt_o = mem_gnt_i AND mem_req_o AND (selected == N); the unselected port's gnt SHALL be 0.
REQ-009 SHALL give a lone requester selection in the same cycle.
REQ-010 SHALL resolve a simultaneous request to the port holding round-robin priority (rr_q).
REQ-011 SHALL update rr_q on each granted handshake to point to the non-granted port; rr_q SHALL hold when there is no handshake.
REQ-012 SHALL push the granted port ID into the ID FIFO on each handshake (mem_req_o AND mem_gnt_i).
REQ-013 SHALL route mem_rvalid_i and mem_rdata_i to the port at the FIFO head and pop that entry.
REQ-014 SHALL drive rdata of the non-head port as 0.
REQ-015 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged, including when the FIFO is full.
REQ-016 SHALL, on mem_rvalid_i with an empty FIFO, drop the response (no portN_rvalid_o), set err_o, and leave err_o set until reset.
REQ-017 SHALL keep request fields unregistered, giving zero added latency on request and response paths.
REQ-018 SHALL keep a request the memory has not granted pending, with no dropping or reordering; the selected port SHALL NOT change while its request is held without grant.

Reset
REQ-019 SHALL, while rst_n = 0 at a clk edge: set rr_q = port0, empty the FIFO, clear lock_q, clear err_o.
REQ-020 SHALL force all outputs to 0 for the whole cycle while rst_n = 0, regardless of inputs.
REQ-021 SHALL discard outstanding transactions when reset is asserted mid-operation; their responses after reset SHALL set err_o.

Configuration
REQ-022 SHALL, with CACHE_ARB_LOCK_EN defined: a handshake with portN_lock_i = 1 sets lock_q to N; while locked, only port N is selectable and rr_q is frozen; lock releases on port N's first handshake with lock_i = 0, or if port N drops req.
REQ-023 SHALL, without CACHE_ARB_LOCK_EN: ignore portN_lock_i, remove lock_q, and use pure round-robin.

Structure
REQ-024 SHALL define port-ID typedef, PORT_ICACHE/PORT_DCACHE constants and the MAX_OUTSTANDING bound in package cache_arb_pkg.
REQ-025 SHALL implement the ID FIFO as sub-module arb_id_fifo: depth MAX_OUTSTANDING, 1-bit entries, same-cycle push/pop, full/empty flags.

Verification
REQ-026 SHALL cover: port0 read 0x0010_0020 alone, memory gnt same cycle, rvalid next cycle with data 0x1234_ABCD -> port0_gnt_o in cycle 0, port0_rvalid_o and data 0x1234_ABCD in cycle 1, port1 silent.
REQ-027 SHALL cover: both ports request every cycle for 4 cycles, gnt always 1 -> grants alternate 0,1,0,1; responses return to matching ports in order.
REQ-028 SHALL cover: MAX_OUTSTANDING = 2, gnt = 1, rvalid withheld -> two grants, then mem_req_o = 0; one rvalid -> forwarding resumes the same cycle.
REQ-029 SHALL cover: with CACHE_ARB_LOCK_EN, port1 issues a 4-beat burst (lock_i = 1,1,1,0) while port0 requests -> port0 gets no grant until after port1's fourth handshake.
REQ-030 SHALL cover: rvalid with an empty FIFO -> no portN_rvalid_o and err_o = 1; then rst_n = 0 for one cycle -> err_o = 0 and all outputs 0.
